// File: rtl/pois_sched.sv
// pois_sched: round-robin front end sharing one Poisson sampler among NREQ
// requesters; owns the 28-bit LFSR that feeds the sampler its random word.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   REQ[NREQ-1:0]       level requests, held until the matching ACK
//   HOLD                suppresses new issues (in-flight sample still completes)
//   SEED_LD, SEED_IN    one-cycle LFSR reseed (zero seed falls back to SEED)
//   PS_VALID, PS_RAND   registered request to the sampler
//   PS_RESULT           sampler result, valid the cycle after PS_VALID
//   ACK, SAMPLE,        one-hot delivery pulse with sample and requester index
//   SAMPLE_ID
//   BUSY                high while the LFSR warms up
//   SAMPLE_CNT          saturating count of delivered samples
module pois_sched #(
   parameter int          NREQ   = 4,
   parameter logic [27:0] SEED   = 28'h5A5A5A5,
   parameter int          WARMUP = 32,
   parameter int          DELAY  = 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [NREQ-1:0] REQ,
   input  logic            HOLD,
   input  logic            SEED_LD,
   input  logic [27:0]     SEED_IN,
   output logic            PS_VALID,
   output logic [27:0]     PS_RAND,
   input  logic [4:0]      PS_RESULT,
   output logic [NREQ-1:0] ACK,
   output logic [4:0]      SAMPLE,
   output logic [2:0]      SAMPLE_ID,
   output logic            BUSY,
   output logic [31:0]     SAMPLE_CNT
);

   // DELAY is accepted for compatibility; registers are modelled without delay.
   if (NREQ < 2 || NREQ > 8 || SEED == 28'd0 || DELAY < 0) begin : g_bad_param
      $error("pois_sched: illegal parameter value");
   end

   typedef enum logic {ST_WARMUP, ST_RUN} state_t;

   state_t          r_state;
   logic [31:0]     r_wcnt;
   logic [27:0]     r_lfsr;
   logic [2:0]      r_ptr;
   logic            r_ps_valid;
   logic [27:0]     r_ps_rand;
   logic [2:0]      r_ps_id;
   logic [NREQ-1:0] r_ack;
   logic [2:0]      r_ack_id;
   logic [31:0]     r_cnt;
   logic            r_busy;

   logic [27:0]     w_lfsr_nxt;
   logic [27:0]     w_seed;
   logic [NREQ-1:0] w_fly_oh;
   logic [NREQ-1:0] w_elig;
   logic            w_found;
   logic [2:0]      w_gnt;
   logic            w_issue;

   // x^28 + x^25 + 1, shifting left
   assign w_lfsr_nxt = {r_lfsr[26:0], r_lfsr[27] ^ r_lfsr[24]};
   assign w_seed     = (SEED_IN == 28'd0) ? SEED : SEED_IN;

   // The requester issued last cycle is still waiting for its ACK,
   // so it sits out this cycle's arbitration.
   assign w_fly_oh = r_ps_valid ? (NREQ'(1) << r_ps_id) : '0;
   assign w_elig   = REQ & ~w_fly_oh;

   // Round robin from r_ptr+1: indices above the pointer outrank the
   // wrapped group; within a group the lowest index wins.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = 3'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_elig[i] && (i <= int'(r_ptr))) begin
            w_found = 1'b1;
            w_gnt   = 3'(i);
         end
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_elig[i] && (i > int'(r_ptr))) begin
            w_found = 1'b1;
            w_gnt   = 3'(i);
         end
      end
   end

   assign w_issue = (r_state == ST_RUN) && !HOLD && !SEED_LD && w_found;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= ST_WARMUP;
         r_wcnt     <= 32'(WARMUP);
         r_lfsr     <= SEED;
         r_ptr      <= 3'(NREQ - 1);
         r_ps_valid <= 1'b0;
         r_ps_rand  <= 28'd0;
         r_ps_id    <= 3'd0;
         r_ack      <= '0;
         r_ack_id   <= 3'd0;
         r_cnt      <= 32'd0;
         r_busy     <= 1'b1;
      end else begin
         // Delivery stage runs regardless of state so an in-flight
         // sample survives a reseed.
         r_ack    <= w_fly_oh;
         r_ack_id <= r_ps_valid ? r_ps_id : 3'd0;
         if (r_ps_valid && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
         end

         r_ps_valid <= w_issue;
         if (w_issue) begin
            r_ps_rand <= r_lfsr;
            r_ps_id   <= w_gnt;
            r_ptr     <= w_gnt;
         end

         if (SEED_LD) begin
            r_lfsr  <= w_seed;
            r_state <= ST_WARMUP;
            r_wcnt  <= 32'(WARMUP);
            r_busy  <= 1'b1;
         end else begin
            case (r_state)
               ST_WARMUP: begin
                  r_lfsr <= w_lfsr_nxt;
                  r_wcnt <= r_wcnt - 32'd1;
                  if (r_wcnt == 32'd1) begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b0;
                  end
               end
               ST_RUN: begin
                  if (w_issue) begin
                     r_lfsr <= w_lfsr_nxt;
                  end
               end
               default: r_state <= ST_WARMUP;
            endcase
         end
      end
   end

   assign PS_VALID   = r_ps_valid;
   assign PS_RAND    = r_ps_rand;
   assign ACK        = r_ack;
   assign SAMPLE     = (|r_ack) ? PS_RESULT : 5'd0;
   assign SAMPLE_ID  = r_ack_id;
   assign BUSY       = r_busy;
   assign SAMPLE_CNT = r_cnt;

endmodule

// File: tb/tb_pois_sched.sv
// tb_pois_sched: scoreboard bench for pois_sched; stimulus pushes expected
// sampler requests and deliveries, a monitor pops them as the DUT emits.
module tb_pois_sched;

   localparam int          NREQ = 4;
   localparam logic [27:0] SEED = 28'h5A5A5A5;
   localparam int          WARM = 32;

   logic            CLK;
   logic            RESET;
   logic [NREQ-1:0] REQ;
   logic            HOLD;
   logic            SEED_LD;
   logic [27:0]     SEED_IN;
   logic            PS_VALID;
   logic [27:0]     PS_RAND;
   logic [4:0]      PS_RESULT;
   logic [NREQ-1:0] ACK;
   logic [4:0]      SAMPLE;
   logic [2:0]      SAMPLE_ID;
   logic            BUSY;
   logic [31:0]     SAMPLE_CNT;

   pois_sched #(
      .NREQ   (NREQ),
      .SEED   (SEED),
      .WARMUP (WARM),
      .DELAY  (1)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ        (REQ),
      .HOLD       (HOLD),
      .SEED_LD    (SEED_LD),
      .SEED_IN    (SEED_IN),
      .PS_VALID   (PS_VALID),
      .PS_RAND    (PS_RAND),
      .PS_RESULT  (PS_RESULT),
      .ACK        (ACK),
      .SAMPLE     (SAMPLE),
      .SAMPLE_ID  (SAMPLE_ID),
      .BUSY       (BUSY),
      .SAMPLE_CNT (SAMPLE_CNT)
   );

   typedef struct {
      int         cyc;
      logic [2:0] id;
      logic [4:0] smp;
   } ack_exp_t;

   typedef struct {
      int          cyc;
      logic [27:0] rnd;
   } rnd_exp_t;

   ack_exp_t    ack_q[$];
   rnd_exp_t    rnd_q[$];
   ack_exp_t    ea;
   rnd_exp_t    er;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [27:0] sw;
   logic [27:0] last_rnd;
   int          ones;
   bit          pv_seen;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Sampler model: registered result one cycle after PS_VALID,
   // junk otherwise so a mistimed capture shows up.
   initial PS_RESULT = 5'd0;
   always @(posedge CLK) PS_RESULT <= PS_VALID ? 5'd7 : 5'd31;

   task automatic chk(input string nm, input bit ok, input string info);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", nm, info);
      end
   endtask

   function automatic logic [27:0] step(input logic [27:0] x);
      return {x[26:0], x[27] ^ x[24]};
   endfunction

   function automatic logic [27:0] warm(input logic [27:0] s);
      logic [27:0] x;
      x = s;
      for (int k = 0; k < WARM; k++) x = step(x);
      return x;
   endfunction

   // Called at the negedge of the cycle in which the issue is decided.
   task automatic expect_issue(input logic [2:0] id, input bit acked);
      rnd_exp_t r;
      ack_exp_t a;
      r.cyc = cyc + 1;
      r.rnd = sw;
      rnd_q.push_back(r);
      last_rnd = sw;
      sw = step(sw);
      if (acked) begin
         a.cyc = cyc + 2;
         a.id  = id;
         a.smp = 5'd7;
         ack_q.push_back(a);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk_reset(input string tg);
      chk({tg, "_psv"}, PS_VALID === 1'b0, $sformatf("got %b want 0", PS_VALID));
      chk({tg, "_psr"}, PS_RAND === 28'd0, $sformatf("got %h want 0", PS_RAND));
      chk({tg, "_ack"}, ACK === 4'd0, $sformatf("got %b want 0", ACK));
      chk({tg, "_smp"}, SAMPLE === 5'd0, $sformatf("got %0d want 0", SAMPLE));
      chk({tg, "_sid"}, SAMPLE_ID === 3'd0, $sformatf("got %0d want 0", SAMPLE_ID));
      chk({tg, "_cnt"}, SAMPLE_CNT === 32'd0, $sformatf("got %0d want 0", SAMPLE_CNT));
      chk({tg, "_busy"}, BUSY === 1'b1, $sformatf("got %b want 1", BUSY));
   endtask

   task automatic busy_window(input string tg);
      ones    = 0;
      pv_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (i > 0) tick();
         if (BUSY === 1'b1) ones++;
         if (PS_VALID === 1'b1) pv_seen = 1;
      end
      chk({tg, "_busy_cycles"}, ones == WARM, $sformatf("got %0d want %0d", ones, WARM));
      chk({tg, "_busy_end"}, BUSY === 1'b0, $sformatf("got %b want 0", BUSY));
      chk({tg, "_no_psv"}, !pv_seen, $sformatf("got %b want 0", pv_seen));
   endtask

   task automatic chk_cnt(input string tg, input int want);
      chk(tg, SAMPLE_CNT === 32'(want), $sformatf("got %0d want %0d", SAMPLE_CNT, want));
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge CLK) begin
      #1;
      if (ACK !== 4'd0) begin
         if (ack_q.size() == 0) begin
            chk("ack_unexpected", 1'b0, $sformatf("got ACK=%b at cyc %0d want none", ACK, cyc));
         end else begin
            ea = ack_q.pop_front();
            chk("ack", (cyc == ea.cyc) && (ACK === (4'd1 << ea.id)) &&
                (SAMPLE_ID === ea.id) && (SAMPLE === ea.smp),
                $sformatf("got cyc %0d ACK %b id %0d smp %0d want cyc %0d id %0d smp %0d",
                          cyc, ACK, SAMPLE_ID, SAMPLE, ea.cyc, ea.id, ea.smp));
         end
      end else begin
         chk("idle_zero", (SAMPLE === 5'd0) && (SAMPLE_ID === 3'd0),
             $sformatf("got smp %0d id %0d want 0 0", SAMPLE, SAMPLE_ID));
      end
      if (PS_VALID === 1'b1) begin
         if (rnd_q.size() == 0) begin
            chk("psv_unexpected", 1'b0, $sformatf("got PS_VALID at cyc %0d want none", cyc));
         end else begin
            er = rnd_q.pop_front();
            chk("ps_rand", (cyc == er.cyc) && (PS_RAND === er.rnd),
                $sformatf("got cyc %0d rand %h want cyc %0d rand %h",
                          cyc, PS_RAND, er.cyc, er.rnd));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET   = 1'b1;
      REQ     = '0;
      HOLD    = 1'b0;
      SEED_LD = 1'b0;
      SEED_IN = 28'd0;
      repeat (3) tick();
      chk_reset("rst");
      RESET = 1'b0;
      sw    = warm(SEED);
      busy_window("warm0");

      // all four requesting: 0,1,2,3,0
      REQ = 4'hF;
      expect_issue(3'd0, 1'b1);
      tick(); expect_issue(3'd1, 1'b1);
      tick(); expect_issue(3'd2, 1'b1);
      tick(); expect_issue(3'd3, 1'b1);
      tick(); expect_issue(3'd0, 1'b1);
      tick(); REQ = '0;
      repeat (4) tick();
      chk_cnt("cnt_rr", 5);

      // single requester held: issue every other cycle
      REQ = 4'b0100;
      expect_issue(3'd2, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("psv_alt", PS_VALID === k[0], $sformatf("got %b want %b (k=%0d)", PS_VALID, k[0], k));
         if (k == 2 || k == 4) expect_issue(3'd2, 1'b1);
         if (k == 6) REQ = '0;
      end
      repeat (4) tick();
      chk_cnt("cnt_single", 8);

      // HOLD blocks issue, PS_RAND holds; REQ dropped before ACK
      REQ  = 4'b0010;
      HOLD = 1'b1;
      tick(); tick();
      chk("hold_psv", PS_VALID === 1'b0, $sformatf("got %b want 0", PS_VALID));
      chk("hold_rand", PS_RAND === last_rnd, $sformatf("got %h want %h", PS_RAND, last_rnd));
      HOLD = 1'b0;
      expect_issue(3'd1, 1'b1);
      tick(); REQ = '0;
      repeat (4) tick();
      chk_cnt("cnt_hold", 9);

      // zero-seed reload with a sample in flight; HOLD during warmup
      REQ = 4'b1000;
      expect_issue(3'd3, 1'b1);
      tick();
      SEED_LD = 1'b1;
      SEED_IN = 28'd0;
      tick();
      SEED_LD = 1'b0;
      REQ     = '0;
      HOLD    = 1'b1;
      sw      = warm(SEED);
      busy_window("seed0");
      HOLD = 1'b0;
      REQ  = 4'b0001;
      expect_issue(3'd0, 1'b1);
      tick(); REQ = '0;
      repeat (4) tick();
      chk_cnt("cnt_seed0", 11);

      // nonzero seed reload
      SEED_LD = 1'b1;
      SEED_IN = 28'h1234567;
      tick();
      SEED_LD = 1'b0;
      SEED_IN = 28'd0;
      sw      = warm(28'h1234567);
      repeat (34) tick();
      chk("seedn_busy", BUSY === 1'b0, $sformatf("got %b want 0", BUSY));
      REQ = 4'b0100;
      expect_issue(3'd2, 1'b1);
      tick(); REQ = '0;
      repeat (4) tick();
      chk_cnt("cnt_seedn", 12);

      // reset the cycle after an issue: no ACK for it
      REQ = 4'b0100;
      expect_issue(3'd2, 1'b0);
      tick();
      RESET = 1'b1;
      REQ   = '0;
      tick();
      chk_reset("rst_mid");
      RESET = 1'b0;
      sw    = warm(SEED);
      repeat (34) tick();
      REQ = 4'hF;
      expect_issue(3'd0, 1'b1);
      tick(); REQ = '0;
      repeat (4) tick();
      chk_cnt("cnt_after_rst", 1);

      chk("ack_q_empty", ack_q.size() == 0, $sformatf("got %0d pending want 0", ack_q.size()));
      chk("rnd_q_empty", rnd_q.size() == 0, $sformatf("got %0d pending want 0", rnd_q.size()));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pois_sched.md
POIS_SCHED -- requirements
Module: pois_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one Poisson sampler (2..8).
REQ-002 Parameter SEED, 28'h5A5A5A5, LFSR reset/fallback seed; SHALL be nonzero.
REQ-003 Parameter WARMUP, 32, LFSR free-run cycles after reset or seed load before first issue.
REQ-004 Parameter DELAY, 1, simulation-only delay on all registered assignments.
REQ-005 CLK  in  1  clock; all logic on rising edge.
REQ-006 RESET  in  1  reset, synchronous, active-high.
REQ-007 REQ  in  NREQ  per-requester level request; held until matching ACK.
REQ-008 HOLD  in  1  when 1, no new issue; in-flight sample still completes.
REQ-009 SEED_LD  in  1  one-cycle pulse: load LFSR from SEED_IN.
REQ-010 SEED_IN  in  28  seed value for SEED_LD.
REQ-011 PS_VALID  out  1  sampler VALID, registered.
REQ-012 PS_RAND  out  28  sampler RAND, registered.
REQ-013 PS_RESULT  in  5  sampler RESULT, registered inside sampler, valid 1 cycle after PS_VALID.
REQ-014 ACK  out  NREQ  one-hot pulse: sample for that requester on SAMPLE.
REQ-015 SAMPLE  out  5  delivered Poisson sample, valid with ACK.
REQ-016 SAMPLE_ID  out  3  index of acked requester, valid with ACK.
REQ-017 BUSY  out  1  1 while in WARMUP state.
REQ-018 SAMPLE_CNT  out  32  total ACKs since reset, saturating at 32'hFFFFFFFF.

Function
REQ-019 States: WARMUP, RUN; reset and SEED_LD enter WARMUP with counter=WARMUP.
REQ-020 WARMUP: LFSR steps every cycle, counter decrements; at counter==1 next state RUN; no issue in WARMUP.
REQ-021 LFSR: 28-bit Fibonacci, polynomial x^28+x^25+1, shifts left, new LSB = bit27 XOR bit24.
REQ-022 SEED_LD with SEED_IN==0 loads SEED parameter instead; LFSR never holds 0.
REQ-023 RUN issue condition: HOLD==0, SEED_LD==0, and at least one eligible requester.
REQ-024 Eligible: REQ[i]==1 and i not the in-flight requester of the previous cycle's issue.
REQ-025 Arbitration: round-robin, search starts at last granted index+1 modulo NREQ; pointer updates only on issue; reset pointer = NREQ-1 (index 0 first).
REQ-026 On issue at cycle t: PS_VALID=1 and PS_RAND=current LFSR at t+1 (registered); LFSR steps once.
REQ-027 In RUN, LFSR steps only on issue.
REQ-028 Cycle after PS_VALID=1: ACK[id]=1, SAMPLE=PS_RESULT, SAMPLE_ID=id, SAMPLE_CNT increments; total latency REQ-to-ACK = 2 cycles when granted immediately.
REQ-029 Throughput: one issue per cycle across distinct requesters; same requester at most every 2 cycles.
REQ-030 When no issue, PS_VALID=0 and PS_RAND holds previous value.
REQ-031 ACK, SAMPLE, SAMPLE_ID are 0 in any cycle without ACK.
REQ-032 SEED_LD in RUN: no issue that cycle; in-flight sample still ACKed next cycle; then WARMUP.
REQ-033 REQ deasserted before ACK: already-issued sample still ACKed; requester not re-granted unless REQ reasserted.
REQ-034 HOLD during WARMUP has no effect on warmup count.

Reset
REQ-035 RESET SHALL set LFSR=SEED, state=WARMUP, counter=WARMUP, RR pointer=NREQ-1, PS_VALID=0, PS_RAND=0, ACK=0, SAMPLE=0, SAMPLE_ID=0, SAMPLE_CNT=0, BUSY=1.
REQ-036 RESET mid-operation discards any in-flight sample; no ACK produced for it.

Verification
REQ-037 Reset, REQ=4'b0000 for 40 cycles -> BUSY=1 for exactly 32 cycles, then 0; PS_VALID never 1.
REQ-038 After warmup, REQ=4'b1111 held, ACK dropped by requester -> grant order 0,1,2,3,0; one ACK per cycle after first; SAMPLE_CNT=5 after 5 ACKs.
REQ-039 Single REQ=4'b0100 held continuously -> ACK[2] every 2nd cycle, SAMPLE_ID=2, PS_VALID alternates 1/0.
REQ-040 Sampler model returns PS_RESULT=5'd7 -> SAMPLE=7 same cycle as ACK; PS_RAND sequence matches software LFSR from SEED after 32 warmup steps.
REQ-041 SEED_LD with SEED_IN=0 while one sample in flight -> that ACK still occurs next cycle; BUSY=1 for 32 cycles; next PS_RAND equals SEED-derived value.
REQ-042 RESET asserted cycle after an issue -> no ACK next cycle; all outputs at REQ-035 values.
